// File: rtl/image_pipe_pkg.sv
// Shared types and 1080p defaults for the image pipeline front end.
// Used by the sync controller, timing generator and debayer.
package image_pipe_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SKIP,
        ARM,
        RUN,
        ERR
    } state_t;

    localparam int ERR_GEOM = 0;
    localparam int ERR_OVF  = 1;

    localparam int H_ACTIVE_1080P = 1920;
    localparam int V_ACTIVE_1080P = 1080;
    localparam int HCNT_W_1080P   = 12;
    localparam int VCNT_W_1080P   = 11;

endpackage

// File: rtl/vid_geom_counter.sv
// Edge detection on frame/line valid plus pixel and line counters.
// Emits line_ok/frame_ok strobes when a line or frame ends with the expected size.
module vid_geom_counter
    import image_pipe_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_1080P,
    parameter int V_ACTIVE = V_ACTIVE_1080P,
    parameter int HCNT_W   = HCNT_W_1080P,
    parameter int VCNT_W   = VCNT_W_1080P
) (
    input  logic clk,
    input  logic reset_n,
    input  logic frame_valid,
    input  logic line_valid,
    output logic fv_fall,
    output logic lv_fall,
    output logic lv_rise,
    output logic line_ok,
    output logic frame_ok
);

    localparam logic [HCNT_W:0] H_EXP = (HCNT_W+1)'(H_ACTIVE);
    localparam logic [VCNT_W:0] V_EXP = (VCNT_W+1)'(V_ACTIVE);

    logic              fv_r;
    logic              lv_r;
    logic [HCNT_W-1:0] hcnt;
    logic [VCNT_W-1:0] vcnt;
    logic [HCNT_W:0]   hlen;
    logic [VCNT_W:0]   vlen;

    assign fv_fall = fv_r & ~frame_valid;
    assign lv_fall = lv_r & ~line_valid;
    assign lv_rise = ~lv_r & line_valid;

    // hcnt restarts at 0 on the first pixel, so the length is hcnt + 1;
    // a line ending with the frame still counts toward the frame total
    assign hlen = {1'b0, hcnt} + (HCNT_W+1)'(1);
    assign vlen = {1'b0, vcnt} + {{VCNT_W{1'b0}}, lv_fall};

    assign line_ok  = lv_fall & (hlen == H_EXP);
    assign frame_ok = fv_fall & (vlen == V_EXP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fv_r <= 1'b0;
            lv_r <= 1'b0;
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            fv_r <= frame_valid;
            lv_r <= line_valid;
            if (lv_rise)
                hcnt <= '0;
            else if (line_valid && hcnt != '1)
                hcnt <= hcnt + HCNT_W'(1);
            if (fv_fall)
                vcnt <= '0;
            else if (lv_fall && vcnt != '1)
                vcnt <= vcnt + VCNT_W'(1);
        end
    end

endmodule

// File: rtl/image_pipe_sync_ctrl.sv
// Locks the image pipeline onto camera video: skips start-up frames,
// arms the timing generator on a frame's first line, and drops lock on errors.
module image_pipe_sync_ctrl
    import image_pipe_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_1080P,
    parameter int V_ACTIVE    = V_ACTIVE_1080P,
    parameter int SKIP_FRAMES = 1,
    parameter int HCNT_W      = HCNT_W_1080P,
    parameter int VCNT_W      = VCNT_W_1080P
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_valid,
    input  logic        line_valid,
    input  logic        fifo_full,
    output logic        gen_rstn,
    output logic        fifo_rst,
    output logic        locked,
    output logic        err_pulse,
    output logic [1:0]  err_code,
    output logic [15:0] frame_cnt
);

    localparam logic [3:0] SKIP_LAST = 4'(SKIP_FRAMES - 1);

    state_t     state;
    state_t     nxt;
    logic [3:0] skip_cnt;
    logic       fv_fall;
    logic       lv_fall;
    logic       lv_rise;
    logic       line_ok;
    logic       frame_ok;
    logic       geom_err;
    logic       ovf_err;

    vid_geom_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .HCNT_W   (HCNT_W),
        .VCNT_W   (VCNT_W)
    ) u_geom (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_valid (frame_valid),
        .line_valid  (line_valid),
        .fv_fall     (fv_fall),
        .lv_fall     (lv_fall),
        .lv_rise     (lv_rise),
        .line_ok     (line_ok),
        .frame_ok    (frame_ok)
    );

    assign geom_err = (lv_fall & ~line_ok) | (fv_fall & ~frame_ok);
    assign ovf_err  = fifo_full & line_valid;

    // Arming needs a fresh line inside the frame so the first hcnt is whole
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: if (!frame_valid) nxt = SKIP;
            SKIP: begin
                if (SKIP_FRAMES == 0)
                    nxt = ARM;
                else if (fv_fall && skip_cnt == SKIP_LAST)
                    nxt = ARM;
            end
            ARM:  if (frame_valid && lv_rise) nxt = RUN;
            RUN:  if (geom_err || ovf_err) nxt = ERR;
            ERR:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            skip_cnt  <= '0;
            gen_rstn  <= 1'b0;
            fifo_rst  <= 1'b1;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_code  <= '0;
            frame_cnt <= '0;
        end else begin
            state     <= nxt;
            gen_rstn  <= (nxt == RUN);
            locked    <= (nxt == RUN);
            err_pulse <= (nxt == ERR);
            fifo_rst  <= (nxt == ARM || nxt == RUN) ? ~frame_valid : 1'b1;
            if (state != SKIP)
                skip_cnt <= '0;
            else if (fv_fall)
                skip_cnt <= skip_cnt + 4'd1;
            if (state == RUN) begin
                if (geom_err) err_code[ERR_GEOM] <= 1'b1;
                if (ovf_err)  err_code[ERR_OVF]  <= 1'b1;
                if (fv_fall && !geom_err && !ovf_err)
                    frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_image_pipe_sync_ctrl.sv
// Directed bench for image_pipe_sync_ctrl with 8x4 frames and one skip frame.
// Frames are driven one pixel per clock; outputs are checked 1ns after posedge.
module tb_image_pipe_sync_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_valid = 1'b0;
    logic        line_valid = 1'b0;
    logic        fifo_full = 1'b0;
    logic        gen_rstn;
    logic        fifo_rst;
    logic        locked;
    logic        err_pulse;
    logic [1:0]  err_code;
    logic [15:0] frame_cnt;

    int n_chk  = 0;
    int n_err  = 0;
    int npulse = 0;

    image_pipe_sync_ctrl #(
        .H_ACTIVE    (8),
        .V_ACTIVE    (4),
        .SKIP_FRAMES (1),
        .HCNT_W      (12),
        .VCNT_W      (11)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_valid (frame_valid),
        .line_valid  (line_valid),
        .fifo_full   (fifo_full),
        .gen_rstn    (gen_rstn),
        .fifo_rst    (fifo_rst),
        .locked      (locked),
        .err_pulse   (err_pulse),
        .err_code    (err_code),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    // a pulse longer than one cycle is counted more than once
    always @(negedge clk) begin
        if (err_pulse === 1'b1) npulse++;
    end

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // nl lines of 8 pixels; short_ln gets 7, ovf_ln sets fifo_full on pixel 3,
    // rst_ln pulses reset on pixel 4, tail_err raises lv+full as fv drops
    task automatic frame(input int nl, input int short_ln, input int ovf_ln,
                         input bit tail_err, input int rst_ln,
                         input bit arm_chk);
        frame_valid = 1'b1;
        step(2);
        for (int l = 0; l < nl; l++) begin
            int np;
            np = (l == short_ln) ? 7 : 8;
            for (int p = 0; p < np; p++) begin
                line_valid = 1'b1;
                fifo_full  = (l == ovf_ln && p == 3);
                if (l == rst_ln && p == 4) begin
                    reset_n = 1'b0;
                    #1;
                    chk("rst_gen_rstn", 16'(gen_rstn), 16'd0);
                    chk("rst_fifo_rst", 16'(fifo_rst), 16'd1);
                    chk("rst_locked", 16'(locked), 16'd0);
                    chk("rst_frame_cnt", frame_cnt, 16'd0);
                    chk("rst_err_code", 16'(err_code), 16'd0);
                    step(1);
                    reset_n = 1'b1;
                end
                if (arm_chk && l == 0 && p == 0)
                    chk("pre_arm_gen_rstn", 16'(gen_rstn), 16'd0);
                step(1);
                if (arm_chk && l == 0 && p == 0) begin
                    chk("arm_gen_rstn", 16'(gen_rstn), 16'd1);
                    chk("arm_locked", 16'(locked), 16'd1);
                    chk("arm_fifo_rst", 16'(fifo_rst), 16'd0);
                end
            end
            line_valid = 1'b0;
            fifo_full  = 1'b0;
            step(3);
        end
        frame_valid = 1'b0;
        if (tail_err) begin
            line_valid = 1'b1;
            fifo_full  = 1'b1;
            step(1);
            line_valid = 1'b0;
            fifo_full  = 1'b0;
        end else begin
            step(1);
        end
        step(4);
    endtask

    initial begin
        step(2);
        chk("reset_gen_rstn", 16'(gen_rstn), 16'd0);
        chk("reset_fifo_rst", 16'(fifo_rst), 16'd1);
        chk("reset_locked", 16'(locked), 16'd0);
        chk("reset_err_pulse", 16'(err_pulse), 16'd0);
        chk("reset_err_code", 16'(err_code), 16'd0);
        chk("reset_frame_cnt", frame_cnt, 16'd0);
        reset_n = 1'b1;
        step(2);

        // start-up: first frame discarded, second arms
        frame(4, -1, -1, 1'b0, -1, 1'b0);
        chk("skip_locked", 16'(locked), 16'd0);
        chk("skip_frame_cnt", frame_cnt, 16'd0);
        frame(4, -1, -1, 1'b0, -1, 1'b1);
        chk("f2_frame_cnt", frame_cnt, 16'd1);
        frame(4, -1, -1, 1'b0, -1, 1'b0);
        chk("f3_frame_cnt", frame_cnt, 16'd2);
        chk("f3_err_code", 16'(err_code), 16'd0);
        chk("gap_fifo_rst", 16'(fifo_rst), 16'd1);
        chk("f3_locked", 16'(locked), 16'd1);

        // overflow only
        frame(4, -1, 1, 1'b0, -1, 1'b0);
        chk("ovf_err_code", 16'(err_code), 16'd2);
        chk("ovf_npulse", 16'(npulse), 16'd1);
        chk("ovf_locked", 16'(locked), 16'd0);
        chk("ovf_gen_rstn", 16'(gen_rstn), 16'd0);
        chk("ovf_err_pulse_low", 16'(err_pulse), 16'd0);
        chk("ovf_frame_cnt", frame_cnt, 16'd2);
        frame(4, -1, -1, 1'b0, -1, 1'b0);
        chk("ovf_skip_locked", 16'(locked), 16'd0);
        frame(4, -1, -1, 1'b0, -1, 1'b1);
        chk("ovf_relock_cnt", frame_cnt, 16'd3);

        // reset during line 2, released mid-line with frame_valid high
        frame(4, -1, -1, 1'b0, 2, 1'b0);
        chk("midrst_locked", 16'(locked), 16'd0);
        chk("midrst_frame_cnt", frame_cnt, 16'd0);
        chk("midrst_npulse", 16'(npulse), 16'd1);
        frame(4, -1, -1, 1'b0, -1, 1'b0);
        chk("midrst_skip_locked", 16'(locked), 16'd0);
        frame(4, -1, -1, 1'b0, -1, 1'b1);
        chk("midrst_relock_cnt", frame_cnt, 16'd1);

        // short line 2
        frame(4, 2, -1, 1'b0, -1, 1'b0);
        chk("short_err_code", 16'(err_code), 16'd1);
        chk("short_npulse", 16'(npulse), 16'd2);
        chk("short_locked", 16'(locked), 16'd0);
        chk("short_gen_rstn", 16'(gen_rstn), 16'd0);
        chk("short_frame_cnt", frame_cnt, 16'd1);
        frame(4, -1, -1, 1'b0, -1, 1'b0);
        chk("short_skip_locked", 16'(locked), 16'd0);
        frame(4, -1, -1, 1'b0, -1, 1'b1);
        chk("short_relock_cnt", frame_cnt, 16'd2);

        // five-line frame
        frame(5, -1, -1, 1'b0, -1, 1'b0);
        chk("vlines_npulse", 16'(npulse), 16'd3);
        chk("vlines_frame_cnt", frame_cnt, 16'd2);
        chk("vlines_locked", 16'(locked), 16'd0);
        chk("vlines_err_code", 16'(err_code), 16'd1);
        frame(4, -1, -1, 1'b0, -1, 1'b0);
        frame(4, -1, -1, 1'b0, -1, 1'b1);
        chk("vlines_relock_cnt", frame_cnt, 16'd3);

        // clear sticky code, then geometry and overflow in one cycle
        reset_n = 1'b0;
        step(1);
        chk("clr_err_code", 16'(err_code), 16'd0);
        reset_n = 1'b1;
        step(2);
        frame(4, -1, -1, 1'b0, -1, 1'b0);
        frame(4, -1, -1, 1'b0, -1, 1'b1);
        chk("both_relock_cnt", frame_cnt, 16'd1);
        frame(3, -1, -1, 1'b1, -1, 1'b0);
        chk("both_err_code", 16'(err_code), 16'd3);
        chk("both_npulse", 16'(npulse), 16'd4);
        chk("both_frame_cnt", frame_cnt, 16'd1);
        chk("both_locked", 16'(locked), 16'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
